gemac_wb_settings: RTL and testbench

Wishbone classic slave on `wb_clk` that holds the GEMAC control settings: misc flags, unicast/multicast MAC addresses and MDIO clock divider. It is the responder for the wishbone write/read transactions the host (or bench) issues to the MAC. Writes land in shadow registers; a commit write copies all shadows to the active outputs atomically, so the MAC never sees a half-updated 48-bit address. It sits between the wishbone interconnect and the MAC core / MDIO master.

---
 rtl/gemac_pkg.sv | 50 +++++
 rtl/gemac_wb_settings.sv | 168 ++++++++++++++++
 tb/tb_gemac_wb_settings.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gemac_pkg.sv
// Shared definitions for the GEMAC wishbone settings block: register word
// offsets, bus FSM states, misc-flag bit positions and reset defaults.
package gemac_pkg;

    // Register word offsets, i.e. wb_adr[7:2]
    localparam logic [5:0] OFS_MISC    = 6'd0;
    localparam logic [5:0] OFS_UCAST_H = 6'd1;
    localparam logic [5:0] OFS_UCAST_L = 6'd2;
    localparam logic [5:0] OFS_MCAST_H = 6'd3;
    localparam logic [5:0] OFS_MCAST_L = 6'd4;
    localparam logic [5:0] OFS_MDIO    = 6'd5;
    localparam logic [5:0] OFS_COMMIT  = 6'd6;
    localparam logic [5:0] OFS_STATUS  = 6'd7;

    // Bit positions inside misc_settings
    localparam int MISC_PAUSE_REQUEST_EN = 5;
    localparam int MISC_PASS_UCAST       = 4;
    localparam int MISC_PASS_MCAST       = 3;
    localparam int MISC_PASS_BCAST       = 2;
    localparam int MISC_PASS_PAUSE       = 1;
    localparam int MISC_PASS_ALL         = 0;

    // Reset defaults
    localparam logic [7:0] RST_MDIO_DIV_DEF = 8'd8;
    localparam logic [5:0] RST_MISC_DEF     = 6'b000000;

    // Bus FSM: one ack cycle followed by a dead cycle that ignores strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } wb_state_e;

    // One complete settings bank (used for both shadow and active copies)
    typedef struct packed {
        logic [5:0]  misc;
        logic [15:0] ucast_h;
        logic [31:0] ucast_l;
        logic [15:0] mcast_h;
        logic [31:0] mcast_l;
        logic [7:0]  mdio_div;
        logic        mdio_nopre;
    } bank_t;

    // Word offsets that decode to a register (STATUS included)
    function automatic logic is_mapped(input logic [5:0] word);
        return (word <= OFS_STATUS);
    endfunction

endpackage

// File: rtl/gemac_wb_settings.sv
// Wishbone classic slave holding GEMAC settings in a shadow bank; a COMMIT
// write copies the whole shadow bank to the active outputs in one edge.
// Optional macro GEMAC_WB_ERR_EN: unmapped accesses and STATUS writes
// answer with wb_err instead of wb_ack.
// Handshake: a transfer is accepted when wb_stb & wb_cyc are sampled high in
// IDLE; the write (or read capture) happens on that edge, wb_ack/wb_err is
// high for exactly the following cycle, then one HOLD cycle ignores strobe.
module gemac_wb_settings
    import gemac_pkg::*;
#(
    parameter logic [7:0] RST_MDIO_DIV = RST_MDIO_DIV_DEF,
    parameter logic [5:0] RST_MISC     = RST_MISC_DEF
) (
    input  logic        wb_clk,
    input  logic        reset,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    input  logic        wb_we,
    input  logic [7:0]  wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        wb_err,
    output logic [5:0]  misc_settings,
    output logic [47:0] ucast_addr,
    output logic [47:0] mcast_addr,
    output logic [7:0]  mdio_div,
    output logic        mdio_nopre,
    output logic        settings_stb,
    output logic        pending,
    output logic [1:0]  dbg_state_o
);

    localparam bank_t RST_BANK = '{
        misc:       RST_MISC,
        ucast_h:    16'h0,
        ucast_l:    32'h0,
        mcast_h:    16'h0,
        mcast_l:    32'h0,
        mdio_div:   RST_MDIO_DIV,
        mdio_nopre: 1'b0
    };

    wb_state_e   state_q, state_d;
    bank_t       shadow_q, shadow_d;
    bank_t       active_q, active_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        stb_q, stb_d;
    logic [31:0] dat_q, dat_d;

    logic [5:0]  word;
    logic        start;
    logic        unused_adr_bits;

    assign word            = wb_adr[7:2];
    assign start           = wb_stb & wb_cyc;
    assign unused_adr_bits = ^wb_adr[1:0];

    // Next-state, register-bank update and response generation
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        stb_d     = 1'b0;
        dat_d     = 32'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACK;
`ifdef GEMAC_WB_ERR_EN
                    if (!is_mapped(word) || (wb_we && word == OFS_STATUS)) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                    end
`else
                    ack_d = 1'b1;
`endif
                    if (wb_we) begin
                        case (word)
                            OFS_MISC:    begin shadow_d.misc    = wb_dat_i[5:0];  pending_d = 1'b1; end
                            OFS_UCAST_H: begin shadow_d.ucast_h = wb_dat_i[15:0]; pending_d = 1'b1; end
                            OFS_UCAST_L: begin shadow_d.ucast_l = wb_dat_i;       pending_d = 1'b1; end
                            OFS_MCAST_H: begin shadow_d.mcast_h = wb_dat_i[15:0]; pending_d = 1'b1; end
                            OFS_MCAST_L: begin shadow_d.mcast_l = wb_dat_i;       pending_d = 1'b1; end
                            OFS_MDIO: begin
                                shadow_d.mdio_div   = wb_dat_i[7:0];
                                shadow_d.mdio_nopre = wb_dat_i[8];
                                pending_d           = 1'b1;
                            end
                            OFS_COMMIT: begin
                                active_d  = shadow_q;
                                pending_d = 1'b0;
                                cnt_d     = cnt_q + 16'd1;
                                stb_d     = 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        case (word)
                            OFS_MISC:    dat_d = {26'h0, shadow_q.misc};
                            OFS_UCAST_H: dat_d = {16'h0, shadow_q.ucast_h};
                            OFS_UCAST_L: dat_d = shadow_q.ucast_l;
                            OFS_MCAST_H: dat_d = {16'h0, shadow_q.mcast_h};
                            OFS_MCAST_L: dat_d = shadow_q.mcast_l;
                            OFS_MDIO:    dat_d = {23'h0, shadow_q.mdio_nopre, shadow_q.mdio_div};
                            OFS_COMMIT:  dat_d = {16'h0, cnt_q};
                            OFS_STATUS:  dat_d = {31'h0, pending_q};
                            default:     dat_d = 32'h0;
                        endcase
                    end
                end
            end
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register bank, asynchronously cleared to reset values
    always_ff @(posedge wb_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shadow_q  <= RST_BANK;
            active_q  <= RST_BANK;
            cnt_q     <= 16'h0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            stb_q     <= 1'b0;
            dat_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            stb_q     <= stb_d;
            dat_q     <= dat_d;
        end
    end

    assign wb_ack        = ack_q;
`ifdef GEMAC_WB_ERR_EN
    assign wb_err        = err_q;
`else
    assign wb_err        = 1'b0 & err_q;
`endif
    assign wb_dat_o      = dat_q;
    assign settings_stb  = stb_q;
    assign pending       = pending_q;
    assign misc_settings = active_q.misc;
    assign ucast_addr    = {active_q.ucast_h, active_q.ucast_l};
    assign mcast_addr    = {active_q.mcast_h, active_q.mcast_l};
    assign mdio_div      = active_q.mdio_div;
    assign mdio_nopre    = active_q.mdio_nopre;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_gemac_wb_settings.sv
// Bench for gemac_wb_settings: directed vector table, hand-written corner
// sequences, then randomized accesses against a word-array reference model.
module tb_gemac_wb_settings;
    import gemac_pkg::*;

    // ---------------- clock / reset ----------------
    logic wb_clk = 1'b0;
    logic reset  = 1'b0;
    always #5 wb_clk = ~wb_clk;

    logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
    logic [7:0]  wb_adr = 8'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_err;
    logic [5:0]  misc_settings;
    logic [47:0] ucast_addr, mcast_addr;
    logic [7:0]  mdio_div;
    logic        mdio_nopre, settings_stb, pending;
    logic [1:0]  dbg_state_o;

    gemac_wb_settings #(.RST_MDIO_DIV(8'd8), .RST_MISC(6'b000000)) dut (
        .wb_clk(wb_clk), .reset(reset),
        .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .wb_err(wb_err),
        .misc_settings(misc_settings), .ucast_addr(ucast_addr), .mcast_addr(mcast_addr),
        .mdio_div(mdio_div), .mdio_nopre(mdio_nopre),
        .settings_stb(settings_stb), .pending(pending), .dbg_state_o(dbg_state_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Registers as masked 32-bit words indexed by word offset 0..5.
    logic [31:0] m_sh [6];
    logic [31:0] m_act[6];
    logic [15:0] m_cnt;
    logic        m_pend;
    logic [31:0] masks[6] = '{32'h3F, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF, 32'hFFFF_FFFF, 32'h1FF};

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i] = 32'h0;
        end
        m_sh[0] = 32'h0;      // misc default 0
        m_sh[5] = 32'h008;    // div 8, nopre 0
        for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
        m_cnt  = 16'h0;
        m_pend = 1'b0;
    endtask

    task automatic model_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                              output logic [31:0] e_rd, output logic e_ack,
                              output logic e_err, output logic e_stb);
        int  w;
        bit  bad;
        w     = int'(adr) / 4;
        bad   = (w > 7) || (we && w == 7);
        e_rd  = 32'h0;
        e_stb = 1'b0;
`ifdef GEMAC_WB_ERR_EN
        e_ack = !bad;
        e_err = bad;
`else
        e_ack = 1'b1;
        e_err = 1'b0;
        bad   = 1'b0;
`endif
        if (we) begin
            if (w < 6) begin
                m_sh[w] = dat & masks[w];
                m_pend  = 1'b1;
            end else if (w == 6) begin
                for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
                m_pend = 1'b0;
                m_cnt  = m_cnt + 16'd1;
                e_stb  = 1'b1;
            end
        end else begin
            if (w < 6)       e_rd = m_sh[w];
            else if (w == 6) e_rd = {16'h0, m_cnt};
            else if (w == 7) e_rd = {31'h0, m_pend};
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_misc"},  misc_settings, m_act[0][5:0]);
        check({tag, "_ucast"}, ucast_addr, {m_act[1][15:0], m_act[2]});
        check({tag, "_mcast"}, mcast_addr, {m_act[3][15:0], m_act[4]});
        check({tag, "_div"},   mdio_div, m_act[5][7:0]);
        check({tag, "_nopre"}, mdio_nopre, m_act[5][8]);
        check({tag, "_pend"},  pending, m_pend);
    endtask

    // ---------------- driver ----------------
    // One full transaction; samples the ack cycle and the following dead cycle.
    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                           input bit hold_stb, output logic [31:0] rd, output logic got_ack,
                           output logic got_err, output logic got_stb);
        @(negedge wb_clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        @(posedge wb_clk); #1;
        rd = wb_dat_o; got_ack = wb_ack; got_err = wb_err; got_stb = settings_stb;
        if (!hold_stb) begin
            wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        end
        @(posedge wb_clk); #1;
        check("ack_width", wb_ack, 1'b0);
        check("err_width", wb_err, 1'b0);
        check("stb_width", settings_stb, 1'b0);
        check("dat_idle",  wb_dat_o, 32'h0);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        @(posedge wb_clk); #1;
    endtask

    task automatic run_op(input string tag, input logic we, input logic [7:0] adr,
                          input logic [31:0] dat, input bit hold_stb, output logic [31:0] rd);
        logic [31:0] e_rd;
        logic e_ack, e_err, e_stb, g_ack, g_err, g_stb;
        model_xfer(we, adr, dat, e_rd, e_ack, e_err, e_stb);
        wb_xfer(we, adr, dat, hold_stb, rd, g_ack, g_err, g_stb);
        check({tag, "_ack"}, g_ack, e_ack);
        check({tag, "_err"}, g_err, e_err);
        check({tag, "_sstb"}, g_stb, e_stb);
        check({tag, "_rd"}, rd, e_rd);
        check_outputs(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        g_ack;
        logic [31:0] e_rd;
        logic e_ack, e_err, e_stb;

        vecs.push_back('{1'b1, 8'h04, 32'h0000_A0B0, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'hC0D0_A1B1, 32'h0});
        vecs.push_back('{1'b0, 8'h1C, 32'h0,         32'h1});          // pending
        vecs.push_back('{1'b1, 8'h18, 32'h1234_5678, 32'h0});          // commit
        vecs.push_back('{1'b0, 8'h1C, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 8'h18, 32'h0,         32'h1});          // commit count
        vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FF3D, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_003D});
        vecs.push_back('{1'b1, 8'h14, 32'h0000_0108, 32'h0});
        vecs.push_back('{1'b0, 8'h14, 32'h0,         32'h0000_0108});
        vecs.push_back('{1'b1, 8'h30, 32'hFFFF_FFFF, 32'h0});          // unmapped
        vecs.push_back('{1'b0, 8'h30, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 8'h1C, 32'h0,         32'h0});          // STATUS write
        vecs.push_back('{1'b1, 8'h0E, 32'hFFFF_1234, 32'h0});          // low adr bits ignored
        vecs.push_back('{1'b0, 8'h0C, 32'h0,         32'h0000_1234});
        vecs.push_back('{1'b1, 8'h11, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 8'hFC, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 8'h18, 32'h0,         32'h0});          // commit #2
        vecs.push_back('{1'b1, 8'h18, 32'h0,         32'h0});          // commit with nothing pending
        vecs.push_back('{1'b0, 8'h18, 32'h0,         32'h3});

        // ---- reset values ----
        model_reset();
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_ack", wb_ack, 1'b0);
        check("rst_state", dbg_state_o, ST_IDLE);
        @(negedge wb_clk);
        reset = 1'b1;
        repeat (2) @(posedge wb_clk);
        #1;
        check("rel_ack", wb_ack, 1'b0);
        check("rel_err", wb_err, 1'b0);
        check("rel_dat", wb_dat_o, 32'h0);
        check("rel_sstb", settings_stb, 1'b0);
        check("rel_div_const", mdio_div, 8'd8);
        check("rel_misc_const", misc_settings, 6'd0);
        check_outputs("rel");

        // ---- table ----
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, 1'b0, rd);
            check($sformatf("vec%0d_table_rd", i), rd, vecs[i].exp_rd);
            if (i == 1) check("pre_commit_ucast", ucast_addr, 48'h0);
            if (i == 3) check("post_commit_ucast", ucast_addr, 48'hA0B0_C0D0_A1B1);
        end

        // ---- strobe held one cycle past ack on COMMIT: single commit ----
        run_op("hold_commit", 1'b1, 8'h18, 32'h0, 1'b1, rd);
        run_op("hold_count", 1'b0, 8'h18, 32'h0, 1'b0, rd);
        check("hold_count_const", rd, 32'h4);

        // ---- reset asserted during the ACK cycle of a COMMIT ----
        run_op("pre_rst_wr", 1'b1, 8'h04, 32'h0000_5555, 1'b0, rd);
        model_xfer(1'b1, 8'h18, 32'h0, e_rd, e_ack, e_err, e_stb);
        @(negedge wb_clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 8'h18; wb_dat_i = 32'h0;
        @(posedge wb_clk); #1;
        check("mid_ack", wb_ack, e_ack);
        check("mid_sstb", settings_stb, 1'b1);
        check("mid_ucast_h", ucast_addr[47:32], 16'h5555);
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_ack", wb_ack, 1'b0);
        check("arst_sstb", settings_stb, 1'b0);
        check("arst_state", dbg_state_o, ST_IDLE);
        check_outputs("arst");
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        @(negedge wb_clk);
        reset = 1'b1;
        @(negedge wb_clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 8'h18;
        @(posedge wb_clk); #1;
        g_ack = wb_ack;
        check("post_rst_ack_latency", g_ack, 1'b1);
        check("post_rst_count", wb_dat_o, 32'h0);
        wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (2) @(posedge wb_clk);
        #1;

        // ---- randomized accesses vs model ----
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [7:0]  adr;
            logic [31:0] dat;
            bit          hold;
            we   = ($urandom_range(0, 1) == 1);
            adr  = 8'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) adr = 8'($urandom_range(32, 255));
            if ($urandom_range(0, 5) == 0) adr = 8'h18;
            dat  = $urandom;
            hold = ($urandom_range(0, 3) == 0);
            run_op($sformatf("rnd%0d", n), we, adr, dat, hold, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
